// File: rtl/uart_8250_rx.sv
// uart_8250_rx
// Serial receive stage of an 8250-compatible UART. Oversamples the
// synchronised serial line at 16x the baud rate, validates the start bit,
// deserialises 5..8 data bits LSB first, checks parity and one stop bit,
// detects break and presents one character plus error flags per frame as a
// single-cycle strobe.
//
// Ports:
//   pclk      - sole clock
//   presetn   - asynchronous active-low reset
//   baud_tick - one-pclk enable pulse at 16x baud rate
//   sin       - asynchronous serial input, idle high
//   wls       - word length (00=5 .. 11=8 bits)
//   pen       - parity enable
//   eps       - even parity select
//   sp        - stick parity
//   rx_data   - received character, zero-extended above the word length
//   rx_valid  - one-pclk strobe qualifying rx_data/pe/fe/bi
//   pe        - parity error
//   fe        - framing error (stop bit sampled low)
//   bi        - break indication (data, parity and stop all low)
//   rx_busy   - high whenever the receiver is not idle

`timescale 1ns/1ps

module uart_8250_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       baud_tick,
    input  logic       sin,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t state;
    state_t state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_prev;
    logic                   fall;
    logic [3:0]             tick_cnt;
    logic                   sample;
    logic [2:0]             bit_idx;
    logic                   last_bit;
    logic [7:0]             shreg;
    logic                   par_acc;
    logic                   all_zero;
    logic                   pe_acc;
    logic [1:0]             lat_wls;
    logic                   lat_pen;
    logic                   lat_eps;
    logic                   lat_sp;

    assign s        = sync_q[SYNC_STAGES-1];
    assign fall     = s_prev & ~s;
    // The sample point sits mid-bit: the tick on which the counter reads 7.
    assign sample   = baud_tick && (tick_cnt == 4'd7);
    assign last_bit = (bit_idx == ({1'b0, lat_wls} + 3'd4));
    assign rx_busy  = (state != IDLE);

    // State register; everything returns to IDLE on reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. All bit-level decisions are made at the sample
    // point, so a stalled baud_tick simply freezes the frame in place.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                end
            end
            START: begin
                if (sample) begin
                    state_n = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && last_bit) begin
                    state_n = lat_pen ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_n = s ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: begin
                if (s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: synchroniser, tick counter, frame accumulation and the
    // registered outputs. Line configuration is captured at the start edge
    // so register writes mid-frame only affect the following frame.
    // all_zero tracks whether every sampled data/parity bit was low; the
    // stop sample completes the break test.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q   <= '1;
            s_prev   <= 1'b1;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            par_acc  <= 1'b0;
            all_zero <= 1'b0;
            pe_acc   <= 1'b0;
            lat_wls  <= 2'b00;
            lat_pen  <= 1'b0;
            lat_eps  <= 1'b0;
            lat_sp   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sin};
            s_prev   <= s;
            rx_valid <= 1'b0;

            if ((state == IDLE) && fall) begin
                tick_cnt <= 4'd0;
            end else if (baud_tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        lat_wls  <= wls;
                        lat_pen  <= pen;
                        lat_eps  <= eps;
                        lat_sp   <= sp;
                        bit_idx  <= 3'd0;
                        shreg    <= 8'h00;
                        par_acc  <= 1'b0;
                        all_zero <= 1'b1;
                        pe_acc   <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg[bit_idx] <= s;
                        par_acc        <= par_acc ^ s;
                        all_zero       <= all_zero & ~s;
                        bit_idx        <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        // Stick parity wants ~eps on the line; otherwise
                        // even parity wants an overall XOR of 0, odd of 1.
                        if (lat_sp) begin
                            pe_acc <= (s == lat_eps);
                        end else if (lat_eps) begin
                            pe_acc <= par_acc ^ s;
                        end else begin
                            pe_acc <= ~(par_acc ^ s);
                        end
                        all_zero <= all_zero & ~s;
                    end
                end
                STOP: begin
                    if (sample) begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                        pe       <= pe_acc;
                        fe       <= ~s;
                        bi       <= all_zero & ~s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_8250_rx.sv
// tb_uart_8250_rx
// Self-checking bench for uart_8250_rx. Directed frames are driven on sin;
// each expected character is pushed onto a scoreboard queue before the frame
// is sent, and a monitor pops and compares whenever rx_valid strobes. The
// monitor also counts baud ticks seen while the receiver is busy, so the
// stop-sample position of every frame is checked as well.

`timescale 1ns/1ps

module tb_uart_8250_rx;

    logic       pclk;
    logic       presetn;
    logic       baud_tick;
    logic       sin;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_busy;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
        int         ticks;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   strobes    = 0;
    int   pushes     = 0;
    int   busy_ticks = 0;
    int   div        = 0;

    uart_8250_rx #(.SYNC_STAGES(2)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .baud_tick (baud_tick),
        .sin       (sin),
        .wls       (wls),
        .pen       (pen),
        .eps       (eps),
        .sp        (sp),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pe        (pe),
        .fe        (fe),
        .bi        (bi),
        .rx_busy   (rx_busy)
    );

    // 100 MHz clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Baud tick every fourth pclk, changed just after the rising edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            div       = (div + 1) % 4;
            baud_tick = (div == 0);
        end
    end

    // Runaway guard.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge pclk); while (baud_tick !== 1'b1);
        end
        #2;
    endtask

    task automatic configure(input logic [1:0] w, input logic p, input logic e, input logic st);
        wls = w;
        pen = p;
        eps = e;
        sp  = st;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic b, input int t);
        exp_t e;
        e.data  = d;
        e.pe    = p;
        e.fe    = f;
        e.bi    = b;
        e.ticks = t;
        sb.push_back(e);
        pushes++;
    endtask

    // Drives one complete frame: start, data LSB first, optional parity, stop.
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit use_par,
                                 input bit par_bit, input bit stop_bit);
        sin = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            sin = data[i];
            wait_ticks(16);
        end
        if (use_par) begin
            sin = par_bit;
            wait_ticks(16);
        end
        sin = stop_bit;
        wait_ticks(16);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        exp_t e;
        if (presetn && rx_valid) begin
            strobes++;
            checkOutput("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                checkOutput("pe", {31'd0, pe}, {31'd0, e.pe});
                checkOutput("fe", {31'd0, fe}, {31'd0, e.fe});
                checkOutput("bi", {31'd0, bi}, {31'd0, e.bi});
                checkOutput("stop_tick", busy_ticks, e.ticks);
            end
        end
        if (!rx_busy && !rx_valid) begin
            busy_ticks = 0;
        end else if (rx_busy && baud_tick) begin
            busy_ticks++;
        end
    end

    initial begin
        presetn = 1'b0;
        sin     = 1'b1;
        configure(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge pclk);
        #2;
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_pe_fe_bi", {29'd0, pe, fe, bi}, 32'd0);
        checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        presetn = 1'b1;
        wait_ticks(4);

        // 8N1, 0xA5: stop sample on tick 152.
        configure(2'b11, 1'b0, 1'b0, 1'b0);
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0, 152);
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        checkOutput("8n1_busy_after", {31'd0, rx_busy}, 32'd0);

        // 7E1, 0x41 with correct then wrong parity bit.
        configure(2'b10, 1'b1, 1'b1, 1'b0);
        push_exp(8'h41, 1'b0, 1'b0, 1'b0, 152);
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1);
        push_exp(8'h41, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);

        // 7O1, 0x41 with parity bit 1 is correct.
        configure(2'b10, 1'b1, 1'b0, 1'b0);
        push_exp(8'h41, 1'b0, 1'b0, 1'b0, 152);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);

        // Stick parity with eps=1 expects a 0 parity bit.
        configure(2'b10, 1'b1, 1'b1, 1'b1);
        push_exp(8'h41, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);
        wait_ticks(4);

        // 5N1, 0x1F with a low stop bit: framing error, then BRK_WAIT.
        configure(2'b00, 1'b0, 1'b0, 1'b0);
        push_exp(8'h1F, 1'b0, 1'b1, 1'b0, 104);
        applyStimulus(8'h1F, 5, 1'b0, 1'b0, 1'b0);
        wait_ticks(32);
        checkOutput("5n1_brk_wait_busy", {31'd0, rx_busy}, 32'd1);
        sin = 1'b1;
        wait_ticks(2);
        checkOutput("5n1_idle_after_high", {31'd0, rx_busy}, 32'd0);
        wait_ticks(8);

        // Break: line low for three 8N1 frame times, exactly one strobe.
        configure(2'b11, 1'b0, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b1, 1'b1, 152);
        sin = 1'b0;
        wait_ticks(300);
        checkOutput("break_busy_mid", {31'd0, rx_busy}, 32'd1);
        wait_ticks(180);
        sin = 1'b1;
        wait_ticks(2);
        checkOutput("break_idle_after", {31'd0, rx_busy}, 32'd0);
        wait_ticks(8);
        push_exp(8'h55, 1'b0, 1'b0, 1'b0, 152);
        applyStimulus(8'h55, 8, 1'b0, 1'b0, 1'b1);
        wait_ticks(8);

        // False start: low for 4 ticks then high.
        sin = 1'b0;
        wait_ticks(4);
        checkOutput("false_start_in_start", {31'd0, rx_busy}, 32'd1);
        sin = 1'b1;
        wait_ticks(16);
        checkOutput("false_start_idle", {31'd0, rx_busy}, 32'd0);

        // One-pclk glitch placed between ticks.
        wait_ticks(1);
        sin = 1'b0;
        @(posedge pclk);
        #2;
        sin = 1'b1;
        wait_ticks(16);
        checkOutput("glitch_idle", {31'd0, rx_busy}, 32'd0);

        // Reset in the middle of data bit 4; rx_data currently holds 0x55.
        sin = 1'b0;
        wait_ticks(16 + 4 * 16 + 8);
        checkOutput("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
        presetn = 1'b0;
        #1;
        checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midreset_pe_fe_bi", {29'd0, pe, fe, bi}, 32'd0);
        checkOutput("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        sin = 1'b1;
        wait_ticks(4);
        presetn = 1'b1;
        wait_ticks(4);
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0, 152);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        wait_ticks(20);

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        checkOutput("strobe_count", strobes, pushes);
        checkOutput("final_busy", {31'd0, rx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_8250_rx.md
# uart_8250_rx

Serial receive stage of the 8250-compatible UART. It sits between the `sin` pad and the receive buffer/FIFO. It oversamples the line at 16x using the baud generator's tick and validates the start bit. It then deserialises 5–8 data bits, checks parity and stop, detects break, and hands one character plus error flags per frame to the receive buffer as a single-cycle strobe.

## Interface
- `SYNC_STAGES`, default 2: number of `sin` synchroniser flops, minimum 2.
- `pclk`  in  1  — sole clock.
- `presetn`  in  1  — asynchronous, active-low reset.
- `baud_tick`  in  1  — one-`pclk` enable pulse at 16x the baud rate, from the baud generator.
- `sin`  in  1  — asynchronous serial input, idle high.
- `wls`  in  2  — word length: 00=5, 01=6, 10=7, 11=8 bits (LCR[1:0]).
- `pen`  in  1  — parity enable (LCR[3]).
- `eps`  in  1  — even parity select (LCR[4]).
- `sp`  in  1  — stick parity (LCR[5]).
- `rx_data`  out  8  — received character, LSB-first reassembled, zero-extended above the word length.
- `rx_valid`  out  1  — one-`pclk` strobe: `rx_data`/`pe`/`fe`/`bi` are valid.
- `pe`  out  1  — parity error for this character.
- `fe`  out  1  — framing error (stop bit sampled 0).
- `bi`  out  1  — break: data, parity and stop all sampled 0.
- `rx_busy`  out  1  — high in any state other than IDLE.

## Operation
- `sin` passes through `SYNC_STAGES` flops, which reset to 1. All logic below uses the synchronised value `s`.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: a falling edge on `s` (previous 1, current 0, evaluated every `pclk`) moves the block to START.
  - The tick counter clears to 0.
  - `wls`/`pen`/`eps`/`sp` are latched for the whole frame. Changes mid-frame take effect on the next frame.
- Tick counter: 4-bit, increments on each `baud_tick` and wraps 15→0. The sample point is the `baud_tick` on which the counter reads 7.
- START: at the sample point, `s`=1 is a false start and the block returns to IDLE with no output. `s`=0 goes to DATA with bit index 0.
- DATA: samples every 16 ticks, shifted in LSB first.
  - After N bits (N=5+`wls`), go to PARITY if `pen`, else STOP.
- PARITY: the expected bit depends on `sp` and `eps`:
  - `sp`=0, `eps`=1: even parity, so the XOR of data bits and the parity bit must be 0.
  - `sp`=0, `eps`=0: odd parity, so that XOR must be 1.
  - `sp`=1: the parity bit must equal ~`eps`.
  - `pe`=1 on mismatch.
- STOP: sample the stop bit. `fe`=~`s`. `bi`=1 if every sampled data bit, parity bit (if enabled) and stop bit is 0.
  - Only one stop bit is checked, regardless of the LCR stop-bit setting.
  - Next state is BRK_WAIT if `s`=0 at the stop sample, else IDLE.
- BRK_WAIT: hold until `s`=1, then IDLE. No new start is detected, and no further `rx_valid` is produced, while the line stays low.
- `rx_data`, `pe`, `fe`, `bi` update together with `rx_valid` and hold their value until the next strobe.
- No backpressure: the consumer must accept `rx_valid` unconditionally. Overrun is the buffer's responsibility.

## Timing
- Reset values:
  - Outputs: `rx_data`=0x00, `rx_valid`=0, `pe`=`fe`=`bi`=0, `rx_busy`=0.
  - Internal: state IDLE, counter 0, synchroniser all 1s.
- Edge-to-START latency: `SYNC_STAGES`+1 `pclk` from a `sin` transition.
- `rx_busy` rises in the `pclk` cycle after the edge is detected.
- Sample k (k=0 is start) is taken on the (8+16k)-th `baud_tick` after entering START. The stop sample is k=1+N+P. For 8N1 that is tick 152.
- `rx_valid` is high for exactly the one `pclk` cycle following the `baud_tick` that took the stop sample.
- From the stop sample, the next state is reached in the same cycle as `rx_valid`:
  - to IDLE, with `rx_busy` low in that cycle; or
  - to BRK_WAIT.
- A new falling edge is accepted in the cycle after return to IDLE. Back-to-back frames with a half-bit stop are therefore received.
- `presetn` asserted mid-frame: immediate return to reset values. The partial frame is discarded and no `rx_valid` is produced.
- `baud_tick` held low: state frozen, no timeout.

## Test plan
- 8N1 (`wls`=11, `pen`=0), send 0xA5 → one `rx_valid` at stop tick 152; `rx_data`=0xA5; `pe`=`fe`=`bi`=0; `rx_busy` low afterwards.
- 7E1 (`wls`=10, `pen`=1, `eps`=1):
  - send 0x41 with parity bit 0 → `rx_data`=0x41, `pe`=0;
  - resend with parity bit 1 → `pe`=1.
  - Stick parity (`sp`=1, `eps`=1) with parity bit 1 → `pe`=1.
- 5N1 send 0x1F with stop bit 0 → `rx_data`=0x1F, `fe`=1, `bi`=0; the block stays in BRK_WAIT until `sin` returns high.
- Break: hold `sin` low for 3 frame times with 8N1 → exactly one `rx_valid` with `rx_data`=0x00, `fe`=1, `bi`=1; after `sin` goes high, a following 0x55 frame is received correctly.
- False start: `sin` low for 4 `baud_tick`s then high → no `rx_valid`, back to IDLE. Glitch of 1 `pclk` width between ticks → no frame.
- Reset: assert `presetn` after data bit 3 of a frame → outputs at reset values immediately, no strobe. After release, a clean 0x3C frame → `rx_data`=0x3C.
